// File: rtl/mp3_stream_fifo.sv
// mp3_stream_fifo: packs IN_W-bit bitstream beats into 32-bit words, buffers
// them in a 2**DEPTH_LOG2-word circular FIFO and presents the head word
// show-ahead to the Mp3Decode bitstream port. Handles end-of-stream with zero
// padding of the final partial word and a sticky stream_done flag.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_clr                   synchronous clear of all state (beats push/pop)
//   i_in_valid/o_in_ready   input beat handshake, i_in_data beat, i_in_last EOS
//   o_fifo_datain           head word, valid while o_fifo_empty=0
//   o_fifo_empty, i_fifo_ren  decoder side of the FIFO
//   o_level                 stored complete words, 0..DEPTH
//   o_stream_done           last beat accepted and all words popped
//   o_word_cnt, o_underrun_cnt  only with MP3_STREAM_FIFO_STATS_EN defined
module mp3_stream_fifo #(
    parameter int unsigned IN_W       = 8,
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [IN_W-1:0]       i_in_data,
    input  logic                  i_in_last,
    output logic [31:0]           o_fifo_datain,
    output logic                  o_fifo_empty,
    input  logic                  i_fifo_ren,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_stream_done
`ifdef MP3_STREAM_FIFO_STATS_EN
    ,
    output logic [31:0]           o_word_cnt,
    output logic [15:0]           o_underrun_cnt
`endif
);

    localparam int unsigned LANES = 32 / IN_W;
    localparam int unsigned PK_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
    localparam int unsigned PTR_W = DEPTH_LOG2;

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [PK_W-1:0]  r_pk;
    logic [31:0]      r_word;
    logic             r_eos;
    logic             r_ready;
    logic             r_empty;
    logic [31:0]      r_head;
    logic             r_done;

    logic             w_accept, w_pop, w_push, w_eos_next;
    logic [4:0]       w_shamt;
    logic [31:0]      w_word, w_head_next;
    logic [PTR_W-1:0] w_wr_next, w_rd_next;
    logic [LVL_W-1:0] w_level_next;

    // Packer: place the accepted beat in its lane; unwritten lanes stay zero
    // because the accumulator is cleared on every push.
    always_comb begin
        w_accept = i_in_valid && r_ready;
        w_pop    = i_fifo_ren && !r_empty;
        w_push   = w_accept && ((r_pk == PK_W'(LANES - 1)) || i_in_last);
        if (BIG_ENDIAN)
            w_shamt = 5'(32 - IN_W - IN_W * 32'(r_pk));
        else
            w_shamt = 5'(IN_W * 32'(r_pk));
        w_word     = r_word | (32'(i_in_data) << w_shamt);
        w_eos_next = r_eos || (w_accept && i_in_last);
    end

    // Pointer and occupancy next state.
    always_comb begin
        w_wr_next    = w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
        w_rd_next    = w_pop  ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + LVL_W'(1);
            2'b01:   w_level_next = r_level - LVL_W'(1);
            default: w_level_next = r_level;
        endcase
    end

    // Show-ahead head: the word being written this edge bypasses the array
    // when it is the next head (push into empty, or push+pop at level 1).
    always_comb begin
        w_head_next = r_head;
        if (w_level_next != '0) begin
            if (w_push && (w_rd_next == r_wr_ptr))
                w_head_next = w_word;
            else
                w_head_next = r_mem[w_rd_next];
        end
    end

    // Storage array carries no reset; only slots below level are ever read.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_clr)
            r_mem[r_wr_ptr] <= w_word;
    end

    // Control, packer and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_pk     <= '0;
            r_word   <= '0;
            r_eos    <= 1'b0;
            r_ready  <= 1'b0;
            r_empty  <= 1'b1;
            r_head   <= '0;
            r_done   <= 1'b0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_pk     <= '0;
            r_word   <= '0;
            r_eos    <= 1'b0;
            r_ready  <= 1'b1;
            r_empty  <= 1'b1;
            r_head   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            r_level  <= w_level_next;
            if (w_push) begin
                r_pk   <= '0;
                r_word <= '0;
            end else if (w_accept) begin
                r_pk   <= r_pk + PK_W'(1);
                r_word <= w_word;
            end
            r_eos   <= w_eos_next;
            // Ready looks at next-state level so a full FIFO never takes a beat.
            r_ready <= (w_level_next != LVL_W'(DEPTH)) && !w_eos_next;
            r_empty <= (w_level_next == '0);
            r_head  <= w_head_next;
            r_done  <= r_done || (w_eos_next && (w_level_next == '0));
        end
    end

    assign o_in_ready    = r_ready;
    assign o_fifo_datain = r_head;
    assign o_fifo_empty  = r_empty;
    assign o_level       = r_level;
    assign o_stream_done = r_done;

`ifdef MP3_STREAM_FIFO_STATS_EN
    logic [31:0] r_word_cnt;
    logic [15:0] r_underrun_cnt;

    // Popped-word counter and saturating underrun counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word_cnt     <= '0;
            r_underrun_cnt <= '0;
        end else if (i_clr) begin
            r_word_cnt     <= '0;
            r_underrun_cnt <= '0;
        end else begin
            if (w_pop)
                r_word_cnt <= r_word_cnt + 32'(1);
            if (i_fifo_ren && r_empty && (r_underrun_cnt != 16'hFFFF))
                r_underrun_cnt <= r_underrun_cnt + 16'(1);
        end
    end

    assign o_word_cnt     = r_word_cnt;
    assign o_underrun_cnt = r_underrun_cnt;
`endif

endmodule

// File: tb/tb_mp3_stream_fifo.sv
// Testbench for mp3_stream_fifo (IN_W=8, DEPTH=64): a big-endian and a
// little-endian instance share stimulus; a queue scoreboard of expected words
// is checked against the head every cycle. Stats ports with
// MP3_STREAM_FIFO_STATS_EN defined.
module tb_mp3_stream_fifo;

    logic        clk = 1'b0;
    logic        rst_n, clr, in_valid, in_last, fifo_ren;
    logic [7:0]  in_data;
    logic        be_ready, be_empty, be_done, le_ready, le_empty, le_done;
    logic [31:0] be_head, le_head;
    logic [6:0]  be_level, le_level;
`ifdef MP3_STREAM_FIFO_STATS_EN
    logic [31:0] be_wcnt, le_wcnt;
    logic [15:0] be_ucnt, le_ucnt;
`endif

    always #5 clk = ~clk;

    mp3_stream_fifo #(.IN_W(8), .DEPTH_LOG2(6), .BIG_ENDIAN(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_in_valid(in_valid),
        .o_in_ready(be_ready), .i_in_data(in_data), .i_in_last(in_last),
        .o_fifo_datain(be_head), .o_fifo_empty(be_empty), .i_fifo_ren(fifo_ren),
        .o_level(be_level), .o_stream_done(be_done)
`ifdef MP3_STREAM_FIFO_STATS_EN
        , .o_word_cnt(be_wcnt), .o_underrun_cnt(be_ucnt)
`endif
    );

    mp3_stream_fifo #(.IN_W(8), .DEPTH_LOG2(6), .BIG_ENDIAN(1'b0)) dut_le (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_in_valid(in_valid),
        .o_in_ready(le_ready), .i_in_data(in_data), .i_in_last(in_last),
        .o_fifo_datain(le_head), .o_fifo_empty(le_empty), .i_fifo_ren(fifo_ren),
        .o_level(le_level), .o_stream_done(le_done)
`ifdef MP3_STREAM_FIFO_STATS_EN
        , .o_word_cnt(le_wcnt), .o_underrun_cnt(le_ucnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [31:0] qb[$];
    logic [31:0] ql[$];
    logic [7:0]  part[$];
    bit          m_ready, m_eos, m_done;
    logic [31:0] m_head, m_le_head;
    int          m_words, m_under;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        r;
        int          exp_level;
        logic        exp_empty;
        logic [31:0] exp_head;
        logic [31:0] exp_le_head;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        qb.delete(); ql.delete(); part.delete();
        m_ready = 1'b0; m_eos = 1'b0; m_done = 1'b0;
        m_head = '0; m_le_head = '0; m_words = 0; m_under = 0;
    endtask

    task automatic check_outputs();
        chk("level", 32'(be_level), 32'(qb.size()));
        chk("empty", 32'(be_empty), 32'(qb.size() == 0));
        chk("head", be_head, m_head);
        chk("le_head", le_head, m_le_head);
        chk("le_level", 32'(le_level), 32'(ql.size()));
        chk("ready", 32'(be_ready), 32'(m_ready));
        chk("done", 32'(be_done), 32'(m_done));
`ifdef MP3_STREAM_FIFO_STATS_EN
        chk("word_cnt", be_wcnt, 32'(m_words));
        chk("underrun_cnt", 32'(be_ucnt), 32'(m_under));
`endif
    endtask

    // One clock: drive inputs, advance model, compare every output.
    task automatic cyc(input logic v, input logic [7:0] d, input logic l,
                       input logic r, input logic c);
        bit          acc, pop;
        logic [31:0] wb, wl;
        in_valid = v; in_data = d; in_last = l; fifo_ren = r; clr = c;
        acc = v && m_ready;
        pop = r && (qb.size() > 0);
        @(posedge clk);
        #1;
        if (c) begin
            qb.delete(); ql.delete(); part.delete();
            m_eos = 1'b0; m_done = 1'b0; m_head = '0; m_le_head = '0;
            m_words = 0; m_under = 0;
        end else begin
            if (pop) begin
                void'(qb.pop_front());
                void'(ql.pop_front());
                m_words++;
            end else if (r && m_under < 65535) begin
                m_under++;
            end
            if (acc) begin
                part.push_back(d);
                if (part.size() == 4 || l) begin
                    wb = '0; wl = '0;
                    foreach (part[i]) begin
                        wb = wb | (32'(part[i]) << (24 - 8 * i));
                        wl = wl | (32'(part[i]) << (8 * i));
                    end
                    qb.push_back(wb);
                    ql.push_back(wl);
                    part.delete();
                end
                if (l) m_eos = 1'b1;
            end
        end
        m_ready = (qb.size() != 64) && !m_eos;
        if (m_eos && qb.size() == 0) m_done = 1'b1;
        if (qb.size() > 0) begin
            m_head    = qb[0];
            m_le_head = ql[0];
        end
        in_valid = 1'b0; in_last = 1'b0; fifo_ren = 1'b0; clr = 1'b0;
        check_outputs();
    endtask

    initial begin
        logic [31:0] held;
        int          k;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        fifo_ren = 1'b0; in_data = '0;
        model_reset();

        vecs[0] = '{1'b1, 8'h49, 1'b0, 1'b0, 0, 1'b1, 32'h0, 32'h0, 1'b1};
        vecs[1] = '{1'b1, 8'h44, 1'b0, 1'b0, 0, 1'b1, 32'h0, 32'h0, 1'b1};
        vecs[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 0, 1'b1, 32'h0, 32'h0, 1'b1};
        vecs[3] = '{1'b1, 8'h04, 1'b0, 1'b0, 1, 1'b0, 32'h49443304, 32'h04334449, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 32'h49443304, 32'h04334449, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 32'h49443304, 32'h04334449, 1'b1};

        // Reset values, then release: ready rises on first edge after release.
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
        chk("ready_after_release", 32'(be_ready), 32'h0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Byte order table.
        for (int i = 0; i < 6; i++) begin
            cyc(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r, 1'b0);
            chk("tbl_level", 32'(be_level), 32'(vecs[i].exp_level));
            chk("tbl_empty", 32'(be_empty), 32'(vecs[i].exp_empty));
            chk("tbl_head", be_head, vecs[i].exp_head);
            chk("tbl_le_head", le_head, vecs[i].exp_le_head);
            chk("tbl_ready", 32'(be_ready), 32'(vecs[i].exp_ready));
        end

        // Full: 256 bytes, no pops.
        for (int i = 0; i < 256; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("full_level", 32'(be_level), 32'd64);
        chk("full_ready", 32'(be_ready), 32'h0);
        cyc(1'b1, 8'hF0, 1'b0, 1'b1, 1'b0);
        chk("pop_full_level", 32'(be_level), 32'd63);
        chk("pop_full_ready", 32'(be_ready), 32'h1);
        cyc(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);

        // Drain to 10, then push+pop on the same edge.
        for (k = 0; k < 100 && qb.size() > 10; k++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (k = 0; k < 8 && part.size() < 3; k++) cyc(1'b1, 8'(k + 8'h60), 1'b0, 1'b0, 1'b0);
        held = qb[1];
        cyc(1'b1, 8'h6F, 1'b0, 1'b1, 1'b0);
        chk("conc_level", 32'(be_level), 32'd10);
        chk("conc_head", be_head, held);

        // Random traffic wrapping the pointers several times.
        for (int i = 0; i < 1000; i++)
            cyc(1'b1, 8'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        for (k = 0; k < 4 && part.size() != 0; k++) cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        for (k = 0; k < 200 && qb.size() > 0; k++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("drained", 32'(qb.size()), 32'd0);

        // Level 1: push+pop replaces the head, empty stays low.
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h23, 1'b0, 1'b1, 1'b0);
        chk("lvl1_head", be_head, 32'h20212223);
        chk("lvl1_empty", 32'(be_empty), 32'h0);

        // Underrun: pops while empty are ignored, head held.
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        held = be_head;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("under_head", be_head, 32'h0);
`ifdef MP3_STREAM_FIFO_STATS_EN
        chk("under_cnt5", 32'(be_ucnt), 32'd5);
`endif
        for (int i = 0; i < 12; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
`ifdef MP3_STREAM_FIFO_STATS_EN
        chk("word_cnt3", be_wcnt, 32'd3);
`endif

        // Partial last word with zero fill, then stream_done.
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
        chk("last_head", be_head, 32'hAABBCC00);
        chk("last_le_head", le_head, 32'h00CCBBAA);
        chk("last_ready", 32'(be_ready), 32'h0);
        cyc(1'b1, 8'hDD, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("done_empty", 32'(be_empty), 32'h1);
        chk("done_flag", 32'(be_done), 32'h1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Last on the final lane: exactly one word.
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h31 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h34, 1'b1, 1'b0, 1'b0);
        chk("last_full_level", 32'(be_level), 32'd1);

        // Clear beats a simultaneous push.
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h41 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h44, 1'b0, 1'b0, 1'b1);
        chk("clr_level", 32'(be_level), 32'd0);
        chk("clr_head", be_head, 32'h0);

        // Asynchronous reset mid-stream (level 20, two bytes packed).
        for (int i = 0; i < 82; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("pre_rst_level", 32'(be_level), 32'd20);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_ready", 32'(be_ready), 32'h0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
